// File: rtl/softplus_fwd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : softplus_fwd_pipe
// Description : Streaming SoftPlus forward activation, y = ln(1 + e^x), on
//               two's-complement Q8.8 samples. Piecewise-linear evaluation with
//               one segment per integer step of x. Three register stages
//               (decode/LUT, multiply, add/mux) with a single global advance
//               enable so that a stalled output freezes the whole pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module softplus_fwd_pipe #(
  parameter int USER_W = 1,
  parameter int LAT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  input  logic [USER_W-1:0] in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [USER_W-1:0] out_user,
  output logic [15:0]       out_count
);

  // Region of x selected by its signed integer part.
  typedef enum logic [1:0] {
    REG_TAB  = 2'd0,  // -8 <= k <= 7 : table interpolation
    REG_ID   = 2'd1,  // k >= 8       : y = x
    REG_ZERO = 2'd2   // k < -8       : y = 0
  } region_e;

  // --------------------------------------------------------------------------
  // Handshake / global advance
  // --------------------------------------------------------------------------
  logic en;
  logic [LAT-1:0] vld_q;

  assign out_valid = vld_q[LAT-1];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en && !rst;

  // --------------------------------------------------------------------------
  // Stage 1 decode: region, fraction, segment base A[k] and slope B[k]
  // --------------------------------------------------------------------------
  logic signed [7:0] k_s;
  region_e           reg1_d;
  logic [10:0]       a1_d;
  logic [8:0]        b1_d;

  assign k_s = $signed(in_data[15:8]);

  // Classify x and look up the segment containing it.
  always_comb begin
    reg1_d = REG_TAB;
    a1_d   = 11'd0;
    b1_d   = 9'd0;
    if (k_s >= 8'sd8) begin
      reg1_d = REG_ID;
    end else if (k_s < -8'sd8) begin
      reg1_d = REG_ZERO;
    end else begin
      // Low nibble of k is unique across -8..7.
      case (in_data[11:8])
        4'h8:    begin a1_d = 11'd0;    b1_d = 9'd0;   end  // k = -8
        4'h9:    begin a1_d = 11'd0;    b1_d = 9'd1;   end  // k = -7
        4'hA:    begin a1_d = 11'd1;    b1_d = 9'd1;   end  // k = -6
        4'hB:    begin a1_d = 11'd2;    b1_d = 9'd3;   end  // k = -5
        4'hC:    begin a1_d = 11'd5;    b1_d = 9'd7;   end  // k = -4
        4'hD:    begin a1_d = 11'd12;   b1_d = 9'd20;  end  // k = -3
        4'hE:    begin a1_d = 11'd32;   b1_d = 9'd48;  end  // k = -2
        4'hF:    begin a1_d = 11'd80;   b1_d = 9'd97;  end  // k = -1
        4'h0:    begin a1_d = 11'd177;  b1_d = 9'd159; end  // k =  0
        4'h1:    begin a1_d = 11'd336;  b1_d = 9'd208; end  // k =  1
        4'h2:    begin a1_d = 11'd544;  b1_d = 9'd236; end  // k =  2
        4'h3:    begin a1_d = 11'd780;  b1_d = 9'd249; end  // k =  3
        4'h4:    begin a1_d = 11'd1029; b1_d = 9'd253; end  // k =  4
        4'h5:    begin a1_d = 11'd1282; b1_d = 9'd255; end  // k =  5
        4'h6:    begin a1_d = 11'd1537; b1_d = 9'd255; end  // k =  6
        default: begin a1_d = 11'd1792; b1_d = 9'd256; end  // k =  7
      endcase
    end
  end

  // Valid bits shift together with the data so bubbles travel with the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[LAT-2:0], in_valid};
    end
  end

  // Stage 1 registers: raw sample, fraction, region and segment coefficients.
  logic [15:0]       x1_q;
  logic [7:0]        f1_q;
  logic [10:0]       a1_q;
  logic [8:0]        b1_q;
  region_e           reg1_q;
  logic [USER_W-1:0] user1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q    <= '0;
      f1_q    <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      reg1_q  <= REG_TAB;
      user1_q <= '0;
    end else if (en) begin
      x1_q    <= in_data;
      f1_q    <= in_data[7:0];
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      reg1_q  <= reg1_d;
      user1_q <= in_user;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: slope times fraction (9b x 8b -> 17b)
  // --------------------------------------------------------------------------
  logic [16:0]       prod2_d;
  logic [16:0]       prod2_q;
  logic [15:0]       x2_q;
  logic [10:0]       a2_q;
  region_e           reg2_q;
  logic [USER_W-1:0] user2_q;

  assign prod2_d = 17'(b1_q) * 17'(f1_q);

  // Stage 2 registers: product plus the fields needed by the final mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod2_q <= '0;
      x2_q    <= '0;
      a2_q    <= '0;
      reg2_q  <= REG_TAB;
      user2_q <= '0;
    end else if (en) begin
      prod2_q <= prod2_d;
      x2_q    <= x1_q;
      a2_q    <= a1_q;
      reg2_q  <= reg1_q;
      user2_q <= user1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: interpolate and select region result
  // --------------------------------------------------------------------------
  logic [15:0] y3_d;
  logic [15:0] tab_y;
  logic        unused_prod_lsb;

  // The fractional product bits are discarded: the shift truncates.
  assign tab_y           = 16'(a2_q) + 16'(prod2_q[16:8]);
  assign unused_prod_lsb = ^prod2_q[7:0];

  // Region mux; table results top out at 0x07FF so the add cannot overflow.
  always_comb begin
    y3_d = 16'd0;
    case (reg2_q)
      REG_ID:   y3_d = x2_q;
      REG_ZERO: y3_d = 16'd0;
      default:  y3_d = tab_y;
    endcase
  end

  logic [15:0]       y3_q;
  logic [USER_W-1:0] user3_q;

  // Output registers hold while the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      y3_q    <= '0;
      user3_q <= '0;
    end else if (en) begin
      y3_q    <= y3_d;
      user3_q <= user2_q;
    end
  end

  assign out_data = y3_q;
  assign out_user = user3_q;

  // --------------------------------------------------------------------------
  // Completed-transfer counter, wraps naturally at 16 bits
  // --------------------------------------------------------------------------
  logic [15:0] cnt_d;
  logic [15:0] cnt_q;

  // Next count: step on every output handshake.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register; reset takes priority over a coincident handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_count = cnt_q;

  // SoftPlus is non-negative; a set sign bit indicates a datapath fault.
  always_ff @(posedge clk) begin
    if (!rst && out_valid) begin
      assert (out_data[15] == 1'b0);
    end
  end

endmodule
`default_nettype wire
